// File: rtl/remote_comm_pkg.sv
// remote_comm_pkg -- shared constants and state types for the robot link.
//   BAUD_DIV_DEF : default clocks per UART bit (50 MHz / 19200 baud)
//   ACK_POS      : byte value the robot returns as a positive acknowledge
//   tx_state_t   : command sequencer states (idle, high byte, low byte)
//   rx_state_t   : UART receiver states
package remote_comm_pkg;

   localparam int         BAUD_DIV_DEF = 2604;
   localparam logic [7:0] ACK_POS      = 8'hA5;

   typedef enum logic [1:0] {
      TX_IDLE    = 2'd0,
      TX_SEND_HI = 2'd1,
      TX_SEND_LO = 2'd2
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

endpackage

// File: rtl/remote_comm_if.sv
// remote_comm_if -- host-side command/response bus of remote_comm.
//   cmd      : 16-bit command word (high byte sent first)
//   snd_cmd  : one-cycle request to send cmd
//   cmd_snt  : both command bytes have left the wire
//   resp_rdy : a response byte has been received
//   resp     : last received response byte
// master = host driving commands, slave = remote_comm.
interface remote_comm_if;
   logic [15:0] cmd;
   logic        snd_cmd;
   logic        cmd_snt;
   logic        resp_rdy;
   logic [7:0]  resp;

   modport master (output cmd, output snd_cmd,
                   input  cmd_snt, input resp_rdy, input resp);
   modport slave  (input  cmd, input snd_cmd,
                   output cmd_snt, output resp_rdy, output resp);
endinterface

// File: rtl/remote_uart.sv
// remote_uart -- 8N1 UART serial datapath, independent TX and RX halves.
//   clk, rst  : system clock, synchronous active-high reset
//   tx_start  : load tx_byte and begin a frame (takes priority over frame end)
//   tx_byte   : byte to frame
//   tx_done   : high the cycle the stop bit completes
//   tx        : serial out, idles high
//   rx        : asynchronous serial in
//   rx_done   : one-cycle strobe at the stop-bit sample point
//   rx_byte   : assembled byte, valid with rx_done
module remote_uart
   import remote_comm_pkg::*;
#(
   parameter int BAUD_DIV = BAUD_DIV_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_start,
   input  logic [7:0] tx_byte,
   output logic       tx_done,
   output logic       tx,
   input  logic       rx,
   output logic       rx_done,
   output logic [7:0] rx_byte
);

   localparam int                CNT_W     = $clog2(BAUD_DIV + 1);
   localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(BAUD_DIV - 1);
   localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);

   // transmit shifter: {stop, data[7:0], start}, shifted out LSB first
   logic             tx_busy_q, tx_busy_d;
   logic [9:0]       tx_sh_q,   tx_sh_d;
   logic [CNT_W-1:0] tx_cnt_q,  tx_cnt_d;
   logic [3:0]       tx_bit_q,  tx_bit_d;

   always_comb begin
      tx_busy_d = tx_busy_q;
      tx_sh_d   = tx_sh_q;
      tx_cnt_d  = tx_cnt_q;
      tx_bit_d  = tx_bit_q;
      tx_done   = 1'b0;
      if (tx_busy_q) begin
         if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_d = '0;
            if (tx_bit_q == 4'd9) begin
               tx_done   = 1'b1;
               tx_busy_d = 1'b0;
               tx_bit_d  = '0;
            end else begin
               tx_sh_d  = {1'b1, tx_sh_q[9:1]};
               tx_bit_d = tx_bit_q + 4'd1;
            end
         end else begin
            tx_cnt_d = tx_cnt_q + CNT_W'(1);
         end
      end
      // a new frame may start on the very cycle the previous one ends
      if (tx_start) begin
         tx_busy_d = 1'b1;
         tx_sh_d   = {1'b1, tx_byte, 1'b0};
         tx_cnt_d  = '0;
         tx_bit_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_busy_q <= 1'b0;
         tx_sh_q   <= '1;
         tx_cnt_q  <= '0;
         tx_bit_q  <= '0;
      end else begin
         tx_busy_q <= tx_busy_d;
         tx_sh_q   <= tx_sh_d;
         tx_cnt_q  <= tx_cnt_d;
         tx_bit_q  <= tx_bit_d;
      end
   end

   assign tx = tx_busy_q ? tx_sh_q[0] : 1'b1;

   // receive: two-flop synchronizer plus one more flop for edge detection
   logic             rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
   rx_state_t        rx_state_q, rx_state_d;
   logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]       rx_bit_q, rx_bit_d;
   logic [7:0]       rx_sh_q,  rx_sh_d;

   always_comb begin
      rx_s1_d    = rx;
      rx_s2_d    = rx_s1_q;
      rx_prev_d  = rx_s2_q;
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_sh_d    = rx_sh_q;
      rx_done    = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (rx_prev_q && !rx_s2_q) begin
               rx_state_d = RX_START;
               rx_cnt_d   = '0;
            end
         end
         RX_START: begin
            // half a bit in: a line back high means a glitch, not a start bit
            if (rx_cnt_q == HALF_LAST) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
            end else begin
               rx_cnt_d = rx_cnt_q + CNT_W'(1);
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d = '0;
               rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
               if (rx_bit_q == 3'd7) begin
                  rx_state_d = RX_STOP;
               end else begin
                  rx_bit_d = rx_bit_q + 3'd1;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + CNT_W'(1);
            end
         end
         RX_STOP: begin
            // the byte is delivered whatever the stop bit's value
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_done    = 1'b1;
               rx_state_d = RX_IDLE;
            end else begin
               rx_cnt_d = rx_cnt_q + CNT_W'(1);
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_prev_q  <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_sh_q    <= '0;
      end else begin
         rx_s1_q    <= rx_s1_d;
         rx_s2_q    <= rx_s2_d;
         rx_prev_q  <= rx_prev_d;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_sh_q    <= rx_sh_d;
      end
   end

   assign rx_byte = rx_sh_q;

endmodule

// File: rtl/remote_comm.sv
// remote_comm -- sends 16-bit commands to the robot as two UART bytes
// (high byte first) and reports each byte the robot sends back.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : remote_comm_if.slave (cmd, snd_cmd, cmd_snt, resp_rdy, resp)
//   TX       : UART serial out to the robot
//   RX       : UART serial in from the robot
// Build option: REMOTE_COMM_RESP_HOLD_EN -- when defined, resp_rdy stays high
// until the next accepted snd_cmd; otherwise it is a one-cycle pulse.
module remote_comm
   import remote_comm_pkg::*;
#(
   parameter int BAUD_DIV = BAUD_DIV_DEF
) (
   input  logic         clk,
   input  logic         rst,
   remote_comm_if.slave bus,
   output logic         TX,
   input  logic         RX
);

   tx_state_t   state_q, state_d;
   logic [15:0] cmd_q, cmd_d;
   logic        cmd_snt_q, cmd_snt_d;
   logic [7:0]  resp_q, resp_d;
   logic        resp_rdy_q, resp_rdy_d;

   logic       tx_start, tx_done, rx_done;
   logic [7:0] tx_byte, rx_byte;

   remote_uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
      .clk      (clk),
      .rst      (rst),
      .tx_start (tx_start),
      .tx_byte  (tx_byte),
      .tx_done  (tx_done),
      .tx       (TX),
      .rx       (RX),
      .rx_done  (rx_done),
      .rx_byte  (rx_byte)
   );

   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      cmd_snt_d = cmd_snt_q;
      tx_start  = 1'b0;
      tx_byte   = cmd_q[15:8];
      case (state_q)
         TX_IDLE: begin
            // the high frame starts straight from the bus so no cycle is lost
            if (bus.snd_cmd) begin
               cmd_d     = bus.cmd;
               cmd_snt_d = 1'b0;
               tx_start  = 1'b1;
               tx_byte   = bus.cmd[15:8];
               state_d   = TX_SEND_HI;
            end
         end
         TX_SEND_HI: begin
            if (tx_done) begin
               tx_start = 1'b1;
               tx_byte  = cmd_q[7:0];
               state_d  = TX_SEND_LO;
            end
         end
         TX_SEND_LO: begin
            if (tx_done) begin
               cmd_snt_d = 1'b1;
               state_d   = TX_IDLE;
            end
         end
         default: state_d = TX_IDLE;
      endcase
   end

   always_comb begin
      resp_d = resp_q;
      if (rx_done) begin
         resp_d = rx_byte;
      end
`ifdef REMOTE_COMM_RESP_HOLD_EN
      resp_rdy_d = resp_rdy_q;
      if (state_q == TX_IDLE && bus.snd_cmd) begin
         resp_rdy_d = 1'b0;
      end
      if (rx_done) begin
         resp_rdy_d = 1'b1;
      end
`else
      resp_rdy_d = rx_done;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= TX_IDLE;
         cmd_q      <= '0;
         cmd_snt_q  <= 1'b0;
         resp_q     <= '0;
         resp_rdy_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         cmd_snt_q  <= cmd_snt_d;
         resp_q     <= resp_d;
         resp_rdy_q <= resp_rdy_d;
      end
   end

   assign bus.cmd_snt  = cmd_snt_q;
   assign bus.resp     = resp_q;
   assign bus.resp_rdy = resp_rdy_q;

endmodule

// File: tb/tb_remote_comm.sv
// tb_remote_comm -- directed self-checking bench for remote_comm (BAUD_DIV=16).
module tb_remote_comm;
   import remote_comm_pkg::*;

   localparam int BD = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic TX;
   logic RX  = 1'b1;

   remote_comm_if bus();

   remote_comm #(.BAUD_DIV(BD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave),
      .TX  (TX),
      .RX  (RX)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   tests = 0;
   int   fails = 0;
   int   rdy_first;
   int   rdy_cnt;
   logic rdy_end;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) step();
   endtask

   task automatic pulse_cmd(input logic [15:0] c, output int t0);
      bus.cmd     = c;
      bus.snd_cmd = 1'b1;
      step();
      t0          = cyc;
      bus.snd_cmd = 1'b0;
      bus.cmd     = ~c;
   endtask

   task automatic sample_frame(input int base, output logic [9:0] bits);
      for (int k = 0; k < 10; k++) begin
         wait_cyc(base + k * BD + BD / 2);
         bits[k] = TX;
      end
   endtask

   task automatic wait_snt(input int limit, output int t);
      t = -1;
      for (int i = 0; i < limit; i++) begin
         if (bus.cmd_snt === 1'b1) begin
            t = cyc;
            break;
         end
         step();
      end
   endtask

   task automatic count_tx_low(input int n, output int lows);
      lows = 0;
      for (int i = 0; i < n; i++) begin
         if (TX !== 1'b1) lows++;
         step();
      end
   endtask

   task automatic send_rx(input logic [7:0] b);
      int idx;
      rdy_first = -1;
      rdy_cnt   = 0;
      for (int i = 0; i < 12 * BD; i++) begin
         idx = i / BD;
         if (idx == 0)      RX = 1'b0;
         else if (idx <= 8) RX = b[idx-1];
         else               RX = 1'b1;
         if (bus.resp_rdy === 1'b1) begin
            if (rdy_first < 0) rdy_first = i;
            rdy_cnt++;
         end
         step();
      end
      rdy_end = bus.resp_rdy;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      tests++;
      if ({TX, bus.cmd_snt, bus.resp_rdy} !== 3'b100) begin
         fails++;
         $display("FAIL reset_ctrl: TX/cmd_snt/resp_rdy=%b required 100", {TX, bus.cmd_snt, bus.resp_rdy});
      end
      tests++;
      if (bus.resp !== 8'h00) begin
         fails++;
         $display("FAIL reset_resp: got %h required 00", bus.resp);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_send();
      int t0, t1, lows;
      logic [9:0] f;
      pulse_cmd(16'h4BF1, t0);
      tests++;
      if (bus.cmd_snt !== 1'b0) begin
         fails++;
         $display("FAIL send_snt_low: got %b required 0", bus.cmd_snt);
      end
      sample_frame(t0, f);
      tests++;
      if (f !== {1'b1, 8'h4B, 1'b0}) begin
         fails++;
         $display("FAIL send_hi_frame: got %b required %b", f, {1'b1, 8'h4B, 1'b0});
      end
      sample_frame(t0 + 10 * BD, f);
      tests++;
      if (f !== {1'b1, 8'hF1, 1'b0}) begin
         fails++;
         $display("FAIL send_lo_frame: got %b required %b", f, {1'b1, 8'hF1, 1'b0});
      end
      wait_snt(30 * BD, t1);
      tests++;
      if (t1 < 0 || (t1 - t0) < 20 * BD - 1 || (t1 - t0) > 20 * BD + 1) begin
         fails++;
         $display("FAIL send_snt_time: got %0d cycles required %0d", (t1 < 0) ? -1 : t1 - t0, 20 * BD);
      end
      count_tx_low(12 * BD, lows);
      tests++;
      if (lows != 0 || bus.cmd_snt !== 1'b1) begin
         fails++;
         $display("FAIL send_idle_after: tx_low=%0d cmd_snt=%b required 0 and 1", lows, bus.cmd_snt);
      end
   endtask

   task automatic test_ignore();
      int t0, t1, lows;
      logic [9:0] f;
      pulse_cmd(16'h4BF1, t0);
      tests++;
      if (bus.cmd_snt !== 1'b0) begin
         fails++;
         $display("FAIL ignore_snt_clear: got %b required 0", bus.cmd_snt);
      end
      wait_cyc(t0 + 5);
      bus.cmd = 16'h57F2;  bus.snd_cmd = 1'b1;  step();  bus.snd_cmd = 1'b0;
      sample_frame(t0, f);
      tests++;
      if (f !== {1'b1, 8'h4B, 1'b0}) begin
         fails++;
         $display("FAIL ignore_hi_frame: got %b required %b", f, {1'b1, 8'h4B, 1'b0});
      end
      wait_cyc(t0 + 10 * BD + 3);
      bus.cmd = 16'h57F2;  bus.snd_cmd = 1'b1;  step();  bus.snd_cmd = 1'b0;
      sample_frame(t0 + 10 * BD, f);
      tests++;
      if (f !== {1'b1, 8'hF1, 1'b0}) begin
         fails++;
         $display("FAIL ignore_lo_frame: got %b required %b", f, {1'b1, 8'hF1, 1'b0});
      end
      wait_snt(30 * BD, t1);
      tests++;
      if (t1 < 0 || (t1 - t0) < 20 * BD - 1 || (t1 - t0) > 20 * BD + 1) begin
         fails++;
         $display("FAIL ignore_snt_time: got %0d cycles required %0d", (t1 < 0) ? -1 : t1 - t0, 20 * BD);
      end
      count_tx_low(12 * BD, lows);
      tests++;
      if (lows != 0) begin
         fails++;
         $display("FAIL ignore_no_extra_frame: tx_low=%0d required 0", lows);
      end
   endtask

   task automatic test_rx_ack();
      send_rx(8'hA5);
      tests++;
      if (bus.resp !== ACK_POS) begin
         fails++;
         $display("FAIL rx_ack_byte: got %h required %h", bus.resp, ACK_POS);
      end
      tests++;
      if (rdy_first < 9 * BD + BD / 2 || rdy_first > 9 * BD + BD / 2 + 4) begin
         fails++;
         $display("FAIL rx_ack_rdy_time: got %0d required %0d..%0d", rdy_first, 9 * BD + BD / 2, 9 * BD + BD / 2 + 4);
      end
   endtask

   task automatic test_resp_hold();
      int t0, t1;
`ifdef REMOTE_COMM_RESP_HOLD_EN
      tests++;
      if (rdy_end !== 1'b1) begin
         fails++;
         $display("FAIL hold_rdy_held: got %b required 1", rdy_end);
      end
      pulse_cmd(16'h0102, t0);
      tests++;
      if (bus.resp_rdy !== 1'b0) begin
         fails++;
         $display("FAIL hold_rdy_clear: got %b required 0", bus.resp_rdy);
      end
`else
      tests++;
      if (rdy_cnt != 1 || rdy_end !== 1'b0) begin
         fails++;
         $display("FAIL pulse_rdy_width: cycles=%0d end=%b required 1 and 0", rdy_cnt, rdy_end);
      end
      pulse_cmd(16'h0102, t0);
`endif
      wait_snt(30 * BD, t1);
      tests++;
      if (t1 < 0) begin
         fails++;
         $display("FAIL hold_cmd_done: got timeout required cmd_snt");
      end
   endtask

   task automatic test_false_start();
      int highs = 0;
      RX = 1'b0;
      repeat (BD / 4) step();
      RX = 1'b1;
      for (int i = 0; i < 12 * BD; i++) begin
         if (bus.resp_rdy !== 1'b0) highs++;
         step();
      end
      tests++;
      if (highs != 0 || bus.resp !== 8'hA5) begin
         fails++;
         $display("FAIL false_start: rdy_cycles=%0d resp=%h required 0 and a5", highs, bus.resp);
      end
   endtask

   task automatic test_concurrent();
      int t0, t1;
      pulse_cmd(16'h1234, t0);
      send_rx(8'h3C);
      tests++;
      if (bus.resp !== 8'h3C || rdy_first < 0) begin
         fails++;
         $display("FAIL concurrent_rx: resp=%h rdy_first=%0d required 3c and >=0", bus.resp, rdy_first);
      end
      wait_snt(30 * BD, t1);
      tests++;
      if (t1 < 0 || (t1 - t0) < 20 * BD - 1 || (t1 - t0) > 20 * BD + 1) begin
         fails++;
         $display("FAIL concurrent_tx: got %0d cycles required %0d", (t1 < 0) ? -1 : t1 - t0, 20 * BD);
      end
   endtask

   task automatic test_reset_mid();
      int t0, lows;
      pulse_cmd(16'h4BF1, t0);
      wait_cyc(t0 + 13 * BD);
      rst = 1'b1;
      step();
      tests++;
      if (TX !== 1'b1 || bus.cmd_snt !== 1'b0 || bus.resp_rdy !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid_ctrl: TX=%b cmd_snt=%b resp_rdy=%b required 1 0 0", TX, bus.cmd_snt, bus.resp_rdy);
      end
      tests++;
      if (bus.resp !== 8'h00) begin
         fails++;
         $display("FAIL reset_mid_resp: got %h required 00", bus.resp);
      end
      rst = 1'b0;
      count_tx_low(12 * BD, lows);
      tests++;
      if (lows != 0 || bus.cmd_snt !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid_quiet: tx_low=%0d cmd_snt=%b required 0 and 0", lows, bus.cmd_snt);
      end
   endtask

   initial begin
      bus.cmd     = 16'h0000;
      bus.snd_cmd = 1'b0;
      test_reset();
      test_send();
      test_ignore();
      test_rx_ack();
      test_resp_hold();
      test_false_start();
      test_concurrent();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/remote_comm.md
REMOTE_COMM -- requirements
Module: remote_comm

Interface
REQ-001 SHALL accept parameter BAUD_DIV, default 2604 (50 MHz / 19200 baud): clocks per UART bit.
REQ-002 SHALL have port clk, input, 1, the single system clock (one clock; reset is synchronous and active-high).
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port cmd, input, 16, command word to transmit.
REQ-005 SHALL have port snd_cmd, input, 1, one-cycle request to send cmd.
REQ-006 SHALL have port cmd_snt, output, 1, both command bytes fully transmitted.
REQ-007 SHALL have port TX, output, 1, UART serial out to the robot.
REQ-008 SHALL have port RX, input, 1, UART serial in from the robot.
REQ-009 SHALL have port resp_rdy, output, 1, response byte available.
REQ-010 SHALL have port resp, output, 8, last received response byte.

Function
REQ-011 SHALL use UART 8N1 framing: idle high, 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each bit exactly BAUD_DIV clocks.
REQ-012 SHALL, on snd_cmd while idle, capture cmd into an internal 16-bit register the same cycle; later changes to cmd do not affect the transfer.
REQ-013 SHALL run states IDLE -> SEND_HI (frame cmd[15:8]) -> SEND_LO (frame cmd[7:0]) -> IDLE; the low frame starts on the clock after the high frame's stop bit ends.
REQ-014 SHALL clear cmd_snt on an accepted snd_cmd and set it on the cycle the low frame's stop bit completes; cmd_snt holds until the next accepted snd_cmd.
REQ-015 SHALL ignore snd_cmd asserted while in SEND_HI or SEND_LO.
REQ-016 SHALL double-flop synchronize RX, with both flops resetting to 1.
REQ-017 SHALL detect a start bit on a synchronized falling edge, sample at BAUD_DIV/2, and abort to idle if the line is high then (false-start rejection).
REQ-018 SHALL sample each data bit and the stop bit at bit centres, BAUD_DIV clocks apart.
REQ-019 SHALL load resp and set resp_rdy at the stop-bit sample regardless of the stop-bit value; resp holds until the next received byte.
REQ-020 SHALL keep transmit and receive paths independent; a response arriving during a transmission is received normally.
REQ-021 SHALL treat positive acknowledge as 8'hA5; the block passes all bytes unfiltered.

Reset
REQ-022 SHALL, with rst high at a clk edge, force TX=1, cmd_snt=0, resp_rdy=0, resp=8'h00, both FSMs idle, and all counters 0.
REQ-023 SHALL abandon an in-flight transmission on reset and drive TX high from the next cycle; no partial frame resumes.

Configuration
REQ-024 SHALL honour macro REMOTE_COMM_RESP_HOLD_EN: when defined, resp_rdy stays high until an accepted snd_cmd or reset clears it; when undefined, resp_rdy is a single-cycle pulse.

Structure
REQ-025 SHALL place BAUD_DIV default, ACK_POS=8'hA5, and the TX/RX state enums in package remote_comm_pkg.
REQ-026 SHALL implement the serial datapath in one sub-module remote_uart (tx shifter + rx shifter); remote_comm holds the command FSM and cmd_snt/resp_rdy logic.

Verification
REQ-027 SHALL verify: cmd=16'h4BF1 plus snd_cmd pulse -> TX frames 0x4B then 0xF1, LSB first; cmd_snt rises exactly 20*BAUD_DIV clocks (+/-1) after snd_cmd.
REQ-028 SHALL verify: RX driven with frame 8'hA5 -> resp=8'hA5, resp_rdy high at the stop-bit centre.
REQ-029 SHALL verify: second snd_cmd with cmd=16'h57F2 during a 16'h4BF1 transfer -> ignored; only 0x4B, 0xF1 are sent.
REQ-030 SHALL verify: rst asserted mid SEND_LO -> TX=1 next cycle, cmd_snt=0, no further frames.
REQ-031 SHALL verify: RX low pulse of BAUD_DIV/4 clocks -> no byte received, resp_rdy stays 0.
REQ-032 SHALL verify, with the macro on and then off: resp_rdy after 8'hA5 -> holds until the next snd_cmd (on) versus a 1-cycle pulse (off).
